// File: rtl/alu_regfile_core_pkg.sv
// -----------------------------------------------------------------------------
// alu_regfile_core_pkg
// Shared constants for the execute/register core of the single-cycle CPU:
// datapath and register-file geometry, ALU operation codes, shift direction
// select and write-back source select.
// -----------------------------------------------------------------------------
package alu_regfile_core_pkg;

    // Datapath width and register-file geometry.
    localparam int DW   = 8;
    localparam int NREG = 8;
    localparam int AW   = $clog2(NREG);

    // ALU operation select (ALUOP).
    localparam logic [2:0] OP_FWD     = 3'b000;
    localparam logic [2:0] OP_ADD     = 3'b001;
    localparam logic [2:0] OP_AND     = 3'b010;
    localparam logic [2:0] OP_OR      = 3'b011;
    localparam logic [2:0] OP_MUL     = 3'b100;
    localparam logic [2:0] OP_ASR     = 3'b101;
    localparam logic [2:0] OP_ROR     = 3'b110;
    localparam logic [2:0] OP_SHL_SHR = 3'b111;

    // Direction for OP_SHL_SHR (SHIFT_CHOICE).
    localparam logic SHIFT_LEFT  = 1'b0;
    localparam logic SHIFT_RIGHT = 1'b1;

    // Write-back source (WB_SEL).
    localparam logic WB_ALU = 1'b0;
    localparam logic WB_MEM = 1'b1;

endpackage

// File: rtl/alu_regfile_core_if.sv
// -----------------------------------------------------------------------------
// alu_regfile_core_if
// Bundles the control/data bus between the CPU control path and the
// execute/register core. There is no handshake on this bus: every signal is
// level-sensitive and sampled by the core on each rising CLK edge (writes) or
// used combinationally (reads, ALU).
//
// Signals (CPU -> core):
//   WRITEENABLE, WRITEREG   register write strobe and destination
//   READREG1, READREG2      source register addresses
//   OPERAND2                ALU operand B (already negated/immediate-selected)
//   ALUOP, SHIFT,           ALU operation, shift amount, shift direction
//   SHIFT_CHOICE
//   WB_SEL, MEMDATA         write-back source select and memory read data
// Signals (core -> CPU):
//   REGOUT1, REGOUT2        asynchronous register read data
//   ALURESULT, ZERO         ALU result (also memory address) and zero flag
//
// Modports: master = CPU control side, slave = the core.
// -----------------------------------------------------------------------------
interface alu_regfile_core_if;
    import alu_regfile_core_pkg::*;

    logic          WRITEENABLE;
    logic [AW-1:0] WRITEREG;
    logic [AW-1:0] READREG1;
    logic [AW-1:0] READREG2;
    logic [DW-1:0] OPERAND2;
    logic [2:0]    ALUOP;
    logic [3:0]    SHIFT;
    logic          SHIFT_CHOICE;
    logic          WB_SEL;
    logic [DW-1:0] MEMDATA;
    logic [DW-1:0] REGOUT1;
    logic [DW-1:0] REGOUT2;
    logic [DW-1:0] ALURESULT;
    logic          ZERO;

    modport master (
        output WRITEENABLE, WRITEREG, READREG1, READREG2, OPERAND2,
               ALUOP, SHIFT, SHIFT_CHOICE, WB_SEL, MEMDATA,
        input  REGOUT1, REGOUT2, ALURESULT, ZERO
    );

    modport slave (
        input  WRITEENABLE, WRITEREG, READREG1, READREG2, OPERAND2,
               ALUOP, SHIFT, SHIFT_CHOICE, WB_SEL, MEMDATA,
        output REGOUT1, REGOUT2, ALURESULT, ZERO
    );

endinterface

// File: rtl/alu_regfile_core_alu_mult8.sv
// -----------------------------------------------------------------------------
// alu_mult8
// Combinational shift-and-add multiplier returning the low DW bits of a*b.
// Because only the low DW bits are kept, the result is identical for signed
// and unsigned interpretations of the operands.
//
// Ports:
//   a    in  DW  multiplicand
//   b    in  DW  multiplier
//   prod out DW  low DW bits of a*b
// -----------------------------------------------------------------------------
module alu_mult8
    import alu_regfile_core_pkg::*;
(
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    output logic [DW-1:0] prod
);

    logic [DW-1:0] acc;

    // One partial product per multiplier bit; bits shifted past the top are
    // dropped, which is exactly the truncation we want.
    always_comb begin
        acc = '0;
        for (int i = 0; i < DW; i++) begin
            if (b[i]) begin
                acc = acc + (a << i);
            end
        end
    end

    assign prod = acc;

endmodule

// File: rtl/alu_regfile_core.sv
// -----------------------------------------------------------------------------
// alu_regfile_core
// Execute/register core of the 8-bit single-cycle CPU: an NREG x DW register
// file (two asynchronous read ports, one synchronous write port), the ALU and
// the write-back mux. No pipelining: ALURESULT is valid in the same cycle the
// inputs settle, and a write lands on the next rising edge.
//
// Ports:
//   CLK    in   clock, all state changes on the rising edge
//   RESET  in   synchronous active-high reset, clears every register
//   bus    slave modport of alu_regfile_core_if (controls in, results out)
// -----------------------------------------------------------------------------
module alu_regfile_core
    import alu_regfile_core_pkg::*;
(
    input  logic               CLK,
    input  logic               RESET,
    alu_regfile_core_if.slave  bus
);

    logic [DW-1:0] regs [NREG];
    logic [DW-1:0] op_a;
    logic [DW-1:0] op_b;
    logic [DW-1:0] mul_res;
    logic [DW-1:0] asr_res;
    logic [DW-1:0] ror_res;
    logic [DW-1:0] shl_res;
    logic [DW-1:0] shr_res;
    logic [2*DW-1:0] ror_dbl;
    logic [2:0]    sh_small;
    logic          sh_big;
    logic [DW-1:0] alu_res;
    logic [DW-1:0] wb_data;

    // ------------------------------------------------------------------
    // Register file. Reset wins over a simultaneous write. Reads are
    // purely combinational with no bypass, so a register being written
    // shows its old value until the edge.
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RESET) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else if (bus.WRITEENABLE) begin
            regs[bus.WRITEREG] <= wb_data;
        end
    end

    assign bus.REGOUT1 = regs[bus.READREG1];
    assign bus.REGOUT2 = regs[bus.READREG2];

    // ------------------------------------------------------------------
    // ALU. Operand A is always read port 1; operand B comes pre-muxed
    // from the CPU.
    // ------------------------------------------------------------------
    assign op_a = bus.REGOUT1;
    assign op_b = bus.OPERAND2;

    alu_mult8 u_mult (
        .a    (op_a),
        .b    (op_b),
        .prod (mul_res)
    );

    // SHIFT[3] set means an amount of 8..15, which pushes every data bit out
    // for the shifts; rotate only uses the amount mod 8.
    assign sh_small = bus.SHIFT[2:0];
    assign sh_big   = bus.SHIFT[3];

    assign asr_res = sh_big ? {DW{op_a[DW-1]}}
                            : DW'($signed(op_a) >>> sh_small);
    // Rotate by shifting a doubled copy: the low half then holds the
    // wrapped-around bits.
    assign ror_dbl = {op_a, op_a} >> sh_small;
    assign ror_res = ror_dbl[DW-1:0];
    assign shl_res = sh_big ? '0 : (op_a << sh_small);
    assign shr_res = sh_big ? '0 : (op_a >> sh_small);

    always_comb begin
        alu_res = '0;
        case (bus.ALUOP)
            OP_FWD:     alu_res = op_b;
            OP_ADD:     alu_res = op_a + op_b;
            OP_AND:     alu_res = op_a & op_b;
            OP_OR:      alu_res = op_a | op_b;
            OP_MUL:     alu_res = mul_res;
            OP_ASR:     alu_res = asr_res;
            OP_ROR:     alu_res = ror_res;
            OP_SHL_SHR: alu_res = (bus.SHIFT_CHOICE == SHIFT_RIGHT) ? shr_res
                                                                     : shl_res;
            default:    alu_res = '0;
        endcase
    end

    assign bus.ALURESULT = alu_res;
    assign bus.ZERO      = (alu_res == '0);

    // ------------------------------------------------------------------
    // Write-back source.
    // ------------------------------------------------------------------
    assign wb_data = (bus.WB_SEL == WB_MEM) ? bus.MEMDATA : alu_res;

endmodule

// File: tb/tb_alu_regfile_core.sv
// -----------------------------------------------------------------------------
// tb_alu_regfile_core
// Directed self-checking bench for alu_regfile_core. Expected values are
// hand-computed constants.
// -----------------------------------------------------------------------------
module tb_alu_regfile_core;
    import alu_regfile_core_pkg::*;

    logic CLK;
    logic RESET;
    int   n_checks;
    int   n_errors;

    alu_regfile_core_if bus ();

    alu_regfile_core dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus.slave)
    );

    // ---------------- clock ----------------
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // ---------------- helpers ----------------
    task automatic check(input string tag, input logic [7:0] obs,
                         input logic [7:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%02h expected 0x%02h", tag, obs, exp);
        end
    endtask

    // Advance past a rising edge and settle.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Load a register through the ALU forward path.
    task automatic write_reg(input logic [2:0] r, input logic [7:0] v);
        bus.ALUOP       = OP_FWD;
        bus.OPERAND2    = v;
        bus.WB_SEL      = WB_ALU;
        bus.WRITEREG    = r;
        bus.WRITEENABLE = 1'b1;
        tick();
        bus.WRITEENABLE = 1'b0;
    endtask

    // Put a value in r1 and select it as operand A, then apply an ALU op.
    task automatic alu_op(input logic [7:0] a, input logic [2:0] op,
                          input logic [7:0] b, input logic [3:0] sh,
                          input logic dir);
        write_reg(3'd1, a);
        bus.READREG1     = 3'd1;
        bus.ALUOP        = op;
        bus.OPERAND2     = b;
        bus.SHIFT        = sh;
        bus.SHIFT_CHOICE = dir;
        #1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        n_checks = 0;
        n_errors = 0;
        RESET            = 1'b1;
        bus.WRITEENABLE  = 1'b0;
        bus.WRITEREG     = '0;
        bus.READREG1     = '0;
        bus.READREG2     = '0;
        bus.OPERAND2     = '0;
        bus.ALUOP        = OP_FWD;
        bus.SHIFT        = '0;
        bus.SHIFT_CHOICE = SHIFT_LEFT;
        bus.WB_SEL       = WB_ALU;
        bus.MEMDATA      = '0;
        tick();
        tick();
        RESET = 1'b0;

        // Reset state: all registers zero, ALU forwards OPERAND2.
        for (int i = 0; i < NREG; i++) begin
            bus.READREG1 = 3'(i);
            #1;
            check($sformatf("reset_r%0d", i), bus.REGOUT1, 8'h00);
        end
        bus.OPERAND2 = 8'h33;
        #1;
        check("reset_fwd", bus.ALURESULT, 8'h33);
        bus.ALUOP = OP_ADD;
        #1;
        check("reset_add", bus.ALURESULT, 8'h33);

        // Reset clears r3 and overrides a simultaneous write.
        write_reg(3'd3, 8'h55);
        bus.READREG1 = 3'd3;
        #1;
        check("pre_reset_r3", bus.REGOUT1, 8'h55);
        bus.ALUOP       = OP_FWD;
        bus.OPERAND2    = 8'h77;
        bus.WRITEREG    = 3'd3;
        bus.WRITEENABLE = 1'b1;
        RESET           = 1'b1;
        tick();
        RESET           = 1'b0;
        bus.WRITEENABLE = 1'b0;
        check("reset_beats_write", bus.REGOUT1, 8'h00);

        // Write/read with old value visible before the edge.
        bus.READREG1    = 3'd2;
        bus.ALUOP       = OP_FWD;
        bus.OPERAND2    = 8'h09;
        bus.WB_SEL      = WB_ALU;
        bus.WRITEREG    = 3'd2;
        bus.WRITEENABLE = 1'b1;
        #1;
        check("r2_before_edge", bus.REGOUT1, 8'h00);
        tick();
        bus.WRITEENABLE = 1'b0;
        check("r2_after_edge", bus.REGOUT1, 8'h09);
        bus.READREG2 = 3'd2;
        #1;
        check("r2_port2", bus.REGOUT2, 8'h09);

        // Arithmetic.
        alu_op(8'h05, OP_ADD, 8'hFD, 4'd0, SHIFT_LEFT);
        check("add_05_fd", bus.ALURESULT, 8'h02);
        check("add_05_fd_zero", {7'd0, bus.ZERO}, 8'h00);
        alu_op(8'h05, OP_ADD, 8'hFB, 4'd0, SHIFT_LEFT);
        check("add_05_fb", bus.ALURESULT, 8'h00);
        check("add_05_fb_zero", {7'd0, bus.ZERO}, 8'h01);
        alu_op(8'hC8, OP_ADD, 8'h64, 4'd0, SHIFT_LEFT);
        check("add_wrap", bus.ALURESULT, 8'h2C);

        // Logic and multiply.
        alu_op(8'h3C, OP_AND, 8'h0F, 4'd0, SHIFT_LEFT);
        check("and", bus.ALURESULT, 8'h0C);
        alu_op(8'h3C, OP_OR, 8'h0F, 4'd0, SHIFT_LEFT);
        check("or", bus.ALURESULT, 8'h3F);
        alu_op(8'h13, OP_MUL, 8'h11, 4'd0, SHIFT_LEFT);
        check("mul_13_11", bus.ALURESULT, 8'h43);
        alu_op(8'hFF, OP_MUL, 8'hFF, 4'd0, SHIFT_LEFT);
        check("mul_ff_ff", bus.ALURESULT, 8'h01);
        alu_op(8'h0D, OP_MUL, 8'h0B, 4'd0, SHIFT_LEFT);
        check("mul_0d_0b", bus.ALURESULT, 8'h8F);

        // Shifts and rotates of 0x96.
        alu_op(8'h96, OP_ASR, 8'h00, 4'd2, SHIFT_LEFT);
        check("asr2", bus.ALURESULT, 8'hE5);
        alu_op(8'h96, OP_ASR, 8'h00, 4'd9, SHIFT_LEFT);
        check("asr9", bus.ALURESULT, 8'hFF);
        alu_op(8'h96, OP_ASR, 8'h00, 4'd0, SHIFT_LEFT);
        check("asr0", bus.ALURESULT, 8'h96);
        alu_op(8'h70, OP_ASR, 8'h00, 4'd9, SHIFT_LEFT);
        check("asr9_pos", bus.ALURESULT, 8'h00);
        alu_op(8'h96, OP_ROR, 8'h00, 4'd3, SHIFT_LEFT);
        check("ror3", bus.ALURESULT, 8'hD2);
        alu_op(8'h96, OP_ROR, 8'h00, 4'd11, SHIFT_LEFT);
        check("ror11", bus.ALURESULT, 8'hD2);
        alu_op(8'h96, OP_ROR, 8'h00, 4'd0, SHIFT_LEFT);
        check("ror0", bus.ALURESULT, 8'h96);
        alu_op(8'h96, OP_SHL_SHR, 8'h00, 4'd1, SHIFT_LEFT);
        check("shl1", bus.ALURESULT, 8'h2C);
        alu_op(8'h96, OP_SHL_SHR, 8'h00, 4'd0, SHIFT_LEFT);
        check("shl0", bus.ALURESULT, 8'h96);
        alu_op(8'h96, OP_SHL_SHR, 8'h00, 4'd8, SHIFT_LEFT);
        check("shl8", bus.ALURESULT, 8'h00);
        alu_op(8'h96, OP_SHL_SHR, 8'h00, 4'd4, SHIFT_RIGHT);
        check("shr4", bus.ALURESULT, 8'h09);
        alu_op(8'h96, OP_SHL_SHR, 8'h00, 4'd8, SHIFT_RIGHT);
        check("shr8", bus.ALURESULT, 8'h00);
        check("shr8_zero", {7'd0, bus.ZERO}, 8'h01);

        // Write-to-self: r1 = r1 + 3 uses the pre-edge value.
        alu_op(8'h05, OP_ADD, 8'h03, 4'd0, SHIFT_LEFT);
        check("self_pre", bus.ALURESULT, 8'h08);
        bus.WRITEREG    = 3'd1;
        bus.WB_SEL      = WB_ALU;
        bus.WRITEENABLE = 1'b1;
        tick();
        bus.WRITEENABLE = 1'b0;
        check("self_reg", bus.REGOUT1, 8'h08);
        check("self_post_alu", bus.ALURESULT, 8'h0B);

        // Memory write-back, then a disabled write leaves it alone.
        bus.ALUOP       = OP_FWD;
        bus.OPERAND2    = 8'h11;
        bus.WB_SEL      = WB_MEM;
        bus.MEMDATA     = 8'hA7;
        bus.WRITEREG    = 3'd5;
        bus.READREG2    = 3'd5;
        bus.WRITEENABLE = 1'b1;
        tick();
        check("wb_mem", bus.REGOUT2, 8'hA7);
        bus.WRITEENABLE = 1'b0;
        bus.MEMDATA     = 8'h3B;
        tick();
        check("we0_hold", bus.REGOUT2, 8'hA7);
        bus.WB_SEL = WB_ALU;
        tick();
        check("we0_hold_alu", bus.REGOUT2, 8'hA7);
        bus.READREG1 = 3'd2;
        #1;
        check("r2_untouched", bus.REGOUT1, 8'h09);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
